// File: rtl/scaled_bitmap_pkg.sv
// Shared defaults for the scaled bitmap object.
// The package holds the default geometry and the coordinate widths. The
// top module imports these values as its parameter defaults.
package scaled_bitmap_pkg;
  localparam int COLS_DEF      = 4;   // bitmap columns (X cells)
  localparam int ROWS_DEF      = 9;   // bitmap rows (Y cells), column word width
  localparam int XW_DEF        = 11;  // X coordinate width
  localparam int YW_DEF        = 10;  // Y coordinate width
  localparam int SW_DEF        = 4;   // scale input width
  localparam int MAX_SCALE_DEF = 7;   // largest honoured scale exponent
endpackage

// File: rtl/scaled_bitmap_bank.sv
// bitmap_bank: double-buffered bitmap storage.
// The shadow bank is written one column at a time. On swap, the active bank
// loads the whole shadow bank. The active bank is read one column word at a
// time by column index.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en/wr_col/wr_data shadow column write
//   swap                copy shadow -> active
//   rd_col / rd_data    combinational active column read
module bitmap_bank #(
  parameter int COLS = 4,
  parameter int ROWS = 9,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            swap,
  input  logic [CW-1:0]   rd_col,
  output logic [ROWS-1:0] rd_data
);

  logic [ROWS-1:0] shadow_q [COLS];
  logic [ROWS-1:0] active_q [COLS];

  // Swap copies the shadow contents from before the clock edge. This means a
  // write in the same cycle lands only in the shadow bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < COLS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
    end else begin
      if (wr_en && (32'(wr_col) < COLS)) shadow_q[wr_col] <= wr_data;
      if (swap) active_q <= shadow_q;
    end
  end

  assign rd_data = active_q[rd_col];

endmodule

// File: rtl/scaled_bitmap.sv
// scaled_bitmap: hit test of a pixel against a scaled 1-bit object bitmap.
// Each bitmap cell is a square of 2^scale pixels. The object origin is at
// (ax, ay). A poll returns the bitmap bit under (poll_x, poll_y). The bit is
// XORed with invert. A pixel outside the object box always returns 0.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   obj_x/obj_y/obj_scale          pending geometry, committed on swap
//   wr_en/wr_col/wr_data           shadow bitmap column write
//   swap                           frame-boundary commit strobe
//   invert, poll_valid, poll_x/y   poll request
//   hit_valid, hit                 result, two cycles after poll_valid
// Handshake: poll_valid is accepted on every rising edge. There is no
// backpressure. hit_valid follows poll_valid exactly two edges later. hit
// is 0 whenever hit_valid is 0.
module scaled_bitmap
  import scaled_bitmap_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int XW        = XW_DEF,
  parameter int YW        = YW_DEF,
  parameter int SW        = SW_DEF,
  parameter int MAX_SCALE = MAX_SCALE_DEF,
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XW-1:0]   obj_x,
  input  logic [YW-1:0]   obj_y,
  input  logic [SW-1:0]   obj_scale,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_col,
  input  logic [ROWS-1:0] wr_data,
  input  logic            swap,
  input  logic            invert,
  input  logic            poll_valid,
  input  logic [XW-1:0]   poll_x,
  input  logic [YW-1:0]   poll_y,
  output logic            hit_valid,
  output logic            hit
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int GW = $clog2(MAX_SCALE + 1);
  // The box edges need enough width to exceed the coordinate range.
  // Otherwise a box that runs off the right or bottom would wrap to small
  // coordinates.
  localparam int XE = XW + CW + MAX_SCALE + 2;
  localparam int YE = YW + RW + MAX_SCALE + 2;

  // Active geometry
  logic [XW-1:0] ax_q, ax_d;
  logic [YW-1:0] ay_q, ay_d;
  logic [GW-1:0] as_q, as_d;

  // Stage 1
  logic            s1_valid_q, s1_valid_d;
  logic            s1_inbox_q, s1_inbox_d;
  logic [RW-1:0]   s1_row_q, s1_row_d;
  logic            s1_inv_q, s1_inv_d;
  logic [ROWS-1:0] s1_word_q;

  // Stage 2
  logic hit_valid_q, hit_valid_d;
  logic hit_q, hit_d;

  logic [XE-1:0]   x_end;
  logic [YE-1:0]   y_end;
  logic [XW-1:0]   dx;
  logic [YW-1:0]   dy;
  logic [CW-1:0]   rd_col;
  logic [ROWS-1:0] rd_word;

  bitmap_bank #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .swap    (swap),
    .rd_col  (rd_col),
    .rd_data (rd_word)
  );

  always_comb begin
    ax_d = ax_q;
    ay_d = ay_q;
    as_d = as_q;
    if (swap) begin
      ax_d = obj_x;
      ay_d = obj_y;
      as_d = (32'(obj_scale) > MAX_SCALE) ? GW'(MAX_SCALE) : GW'(obj_scale);
    end

    x_end  = XE'(ax_q) + (XE'(COLS) << as_q);
    y_end  = YE'(ay_q) + (YE'(ROWS) << as_q);
    dx     = poll_x - ax_q;
    dy     = poll_y - ay_q;
    // The offsets are meaningful only inside the box. Outside the box the
    // column and row indices are don't-care, because the in-box flag
    // masks them.
    rd_col = CW'(dx >> as_q);

    s1_valid_d = poll_valid;
    s1_inbox_d = (poll_x >= ax_q) && (XE'(poll_x) < x_end) &&
                 (poll_y >= ay_q) && (YE'(poll_y) < y_end);
    s1_row_d   = RW'(dy >> as_q);
    s1_inv_d   = invert;

    hit_valid_d = s1_valid_q;
    hit_d       = s1_valid_q & s1_inbox_q & (s1_word_q[s1_row_q] ^ s1_inv_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ax_q        <= '0;
      ay_q        <= '0;
      as_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_inbox_q  <= 1'b0;
      s1_row_q    <= '0;
      s1_inv_q    <= 1'b0;
      s1_word_q   <= '0;
      hit_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      ax_q        <= ax_d;
      ay_q        <= ay_d;
      as_q        <= as_d;
      s1_valid_q  <= s1_valid_d;
      s1_inbox_q  <= s1_inbox_d;
      s1_row_q    <= s1_row_d;
      s1_inv_q    <= s1_inv_d;
      s1_word_q   <= rd_word;
      hit_valid_q <= hit_valid_d;
      hit_q       <= hit_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_scaled_bitmap.sv
// Directed testbench for scaled_bitmap.
// Each step drives one cycle of inputs and pushes the expected
// {hit_valid, hit} pair into exp_q. The pair is checked one edge later,
// which is when that poll reaches the outputs.
module tb_scaled_bitmap;
  logic        clk;
  logic        reset;
  logic [10:0] obj_x;
  logic [9:0]  obj_y;
  logic [3:0]  obj_scale;
  logic        wr_en;
  logic [1:0]  wr_col;
  logic [8:0]  wr_data;
  logic        swap;
  logic        invert;
  logic        poll_valid;
  logic [10:0] poll_x;
  logic [9:0]  poll_y;
  logic        hit_valid;
  logic        hit;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  string      tag_q[$];

  scaled_bitmap dut (
    .clk        (clk),
    .reset      (reset),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_scale  (obj_scale),
    .wr_en      (wr_en),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .swap       (swap),
    .invert     (invert),
    .poll_valid (poll_valid),
    .poll_x     (poll_x),
    .poll_y     (poll_y),
    .hit_valid  (hit_valid),
    .hit        (hit)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {hit_valid,hit}=%b want %b", tag, act, exp);
    end
  endtask

  // One clock cycle. The inputs are driven before this call. One-shot
  // strobes are released 1ns after the edge.
  task automatic step(input logic [1:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) check(tag_q.pop_front(), {hit_valid, hit}, exp_q.pop_front());
    wr_en      = 1'b0;
    swap       = 1'b0;
    poll_valid = 1'b0;
    invert     = 1'b0;
  endtask

  task automatic idle();
    step(2'b00, "idle");
  endtask

  task automatic poll(input int x, input int y, input logic inv, input logic h, input string tag);
    poll_valid = 1'b1;
    poll_x     = 11'(x);
    poll_y     = 10'(y);
    invert     = inv;
    step({1'b1, h}, tag);
  endtask

  task automatic write(input int col, input logic [8:0] data);
    wr_en   = 1'b1;
    wr_col  = 2'(col);
    wr_data = data;
  endtask

  task automatic set_swap(input int x, input int y, input int s);
    swap      = 1'b1;
    obj_x     = 11'(x);
    obj_y     = 10'(y);
    obj_scale = 4'(s);
  endtask

  initial begin
    reset = 1'b1;
    obj_x = '0; obj_y = '0; obj_scale = '0;
    wr_en = 1'b0; wr_col = '0; wr_data = '0;
    swap = 1'b0; invert = 1'b0; poll_valid = 1'b0;
    poll_x = '0; poll_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {hit_valid, hit}, 2'b00);
    reset = 1'b0;
    exp_q.push_back(2'b00);
    tag_q.push_back("post_rst_s1");

    // Before any swap: the box is at (0,0), scale 0, and the bitmap is empty.
    idle();
    poll(0, 0, 1'b1, 1'b1, "empty_inv_origin");
    poll(3, 8, 1'b1, 1'b1, "empty_inv_corner");
    poll(4, 0, 1'b1, 1'b0, "empty_inv_outside");
    poll(1, 1, 1'b0, 1'b0, "empty_noinv");

    // Shadow: col1 row2, col3 rows 0 and 8. col0 = 1FF is written in the
    // same cycle as the swap.
    write(1, 9'b000000100); idle();
    write(3, 9'h101);       idle();
    write(0, 9'h1FF); set_swap(100, 50, 2); idle();

    poll(100, 50, 1'b0, 1'b0, "col0_prewrite");
    poll(104, 58, 1'b0, 1'b1, "col1_row2_hit");
    poll(103, 58, 1'b0, 1'b0, "col0_row2_miss");
    poll(116, 50, 1'b0, 1'b0, "right_edge_excl");
    poll(99,  50, 1'b0, 1'b0, "left_miss");
    poll(115, 85, 1'b0, 1'b1, "col3_row8");
    poll(115, 86, 1'b0, 1'b0, "bottom_edge_excl");
    poll(108, 50, 1'b1, 1'b1, "inv_empty_in");
    poll(116, 50, 1'b1, 1'b0, "inv_outside");

    // A swap at the acceptance edge does not affect that poll.
    set_swap(100, 50, 2);
    poll(100, 50, 1'b0, 1'b0, "swap_same_edge");
    poll(100, 50, 1'b0, 1'b1, "col0_after_swap");

    // A scale of 15 is clamped to 7. The box is then 512 pixels wide.
    set_swap(100, 50, 15); idle();
    poll(611, 50, 1'b0, 1'b1, "clamp_last_in");
    poll(612, 50, 1'b0, 1'b0, "clamp_first_out");
    poll(612, 50, 1'b1, 1'b0, "clamp_out_inv");

    // A box that runs past x = 2047 clips. It does not wrap to low x.
    set_swap(2000, 50, 7); idle();
    poll(5, 50, 1'b1, 1'b0, "clip_no_alias");
    poll(2047, 50, 1'b0, 1'b1, "clip_max_x");

    // Reset with a poll in flight
    poll(108, 50, 1'b1, 1'b1, "rst_inflight");
    reset = 1'b1;
    #2;
    check("rst_async", {hit_valid, hit}, 2'b00);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(2'b00);
    tag_q.push_back("rst_flushed");
    idle();
    idle();
    poll(100, 50, 1'b1, 1'b0, "post_rst_outside");
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scaled_bitmap.md
SCALED_BITMAP -- requirements
Module: scaled_bitmap

Interface
REQ-001 Parameter COLS, 4, bitmap columns (X cells).
REQ-002 Parameter ROWS, 9, bitmap rows (Y cells); column word width.
REQ-003 Parameter XW, 11, X coordinate width.
REQ-004 Parameter YW, 10, Y coordinate width.
REQ-005 Parameter SW, 4, scale input width.
REQ-006 Parameter MAX_SCALE, 7, largest honoured scale exponent.
REQ-007 Port clk  in  1  sole clock, rising edge.
REQ-008 Port reset  in  1  asynchronous, active-high reset.
REQ-009 Port obj_x / obj_y  in  XW / YW  pending object origin (top-left).
REQ-010 Port obj_scale  in  SW  pending scale exponent; cell = 2^scale pixels square.
REQ-011 Port wr_en  in  1  shadow bitmap column write strobe.
REQ-012 Port wr_col  in  clog2(COLS)  column index to write.
REQ-013 Port wr_data  in  ROWS  column word; bit r = row r, row 0 at top.
REQ-014 Port swap  in  1  frame-boundary strobe (vsync); commits shadow and geometry.
REQ-015 Port invert  in  1  inverted mode for the accompanying poll.
REQ-016 Port poll_valid  in  1  poll request qualifier.
REQ-017 Port poll_x / poll_y  in  XW / YW  pixel to test.
REQ-018 Port hit_valid  out  1  result qualifier, poll_valid delayed 2 cycles.
REQ-019 Port hit  out  1  result; 0 whenever hit_valid is 0.

Function
REQ-020 Two bitmap banks SHALL exist: shadow (written) and active (polled), each COLS x ROWS bits.
REQ-021 wr_en with wr_col < COLS SHALL write wr_data into shadow column wr_col at the clock edge; wr_col >= COLS SHALL be ignored.
REQ-022 On swap, active bitmap SHALL load shadow, and active geometry SHALL load obj_x, obj_y, min(obj_scale, MAX_SCALE); shadow is unchanged.
REQ-023 wr_en and swap in the same cycle: write SHALL land in shadow; active SHALL receive pre-write shadow contents.
REQ-024 Object box SHALL be ax <= poll_x < ax + (COLS << as) and ay <= poll_y < ay + (ROWS << as); right/bottom edges exclusive.
REQ-025 Box arithmetic SHALL be carried at full width (no wrap); boxes extending past coordinate range clip, never alias to 0.
REQ-026 Stage 1 (poll cycle N): compute in-box, column index (poll_x-ax)>>as, row index (poll_y-ay)>>as; register in-box, row index, invert, and the selected active column word.
REQ-027 Stage 2: register hit = in_box & (word[row] XOR invert); hit_valid and hit appear at edge N+2.
REQ-028 Each poll SHALL use active bitmap and geometry as they stood at its acceptance edge; a swap at the same or a later edge SHALL NOT affect it.
REQ-029 Out-of-box polls SHALL return hit = 0 regardless of invert.
REQ-030 Polls are accepted every cycle back-to-back; throughput one per clock, no stall.

Reset
REQ-031 Reset SHALL asynchronously clear both banks, active geometry (0,0,scale 0), both pipeline stages, hit_valid and hit.
REQ-032 Reset mid-pipeline SHALL discard in-flight polls; no hit_valid until a poll accepted after reset deassertion.
REQ-033 After reset and before any swap, every poll SHALL return hit = 0 (invert excepted inside the 0,0 box).

Structure
REQ-034 Shared package SHALL hold default COLS, ROWS, XW, YW, SW, MAX_SCALE.
REQ-035 Sub-module bitmap_bank SHALL implement shadow/active storage, write, swap, and column-select read.

Verification
REQ-036 Geometry (100,50), scale 2, write col1 = 9'b000000100, swap; poll (104,58) -> hit=1 at N+2; poll (103,58) -> 0.
REQ-037 Same setup; poll (116,50) and (99,50) -> 0 (exclusive right edge, left miss); poll (115,85) -> value of col3 row8.
REQ-038 Write col0 = 9'h1FF with swap same cycle, previous shadow col0 = 0; poll (100,50) -> 0; after second swap -> 1.
REQ-039 obj_scale = 15 swapped in -> behaves as 7: poll (100+511, 50) -> in box, (100+512, 50) -> 0.
REQ-040 invert=1 on empty in-box cell -> 1, outside box -> 0; reset asserted at N+1 -> no hit_valid at N+2, all outputs 0.
